imem_rot_ctrl: RTL and testbench

//  Sequencer for the 192-byte BGR tile buffer (input_mem). FILL: steers 32-bit bus words into byte addresses.

---
 rtl/imem_rot_ctrl_if.sv | 38 +++
 rtl/imem_rot_ctrl.sv | 153 +++++++++++++++
 tb/tb_imem_rot_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_rot_ctrl_if.sv
// imem_rot_ctrl_if: handshake and address bundle for the tile-buffer sequencer.
//   slave  : the sequencer (imem_rot_ctrl). It takes START/ROT/RVALID/OMEM_READY
//            and drives RREADY, the buffer write/read byte addresses and pixel status.
//   master : the environment (bus word source, output-memory sink, controller).
interface imem_rot_ctrl_if;
  logic       I_IMC_START;
  logic [1:0] I_IMC_ROT;
  logic       I_IMC_RVALID;
  logic       O_IMC_RREADY;
  logic       I_IMC_OMEM_READY;
  logic [7:0] O_IMC_PIXEL_IN_ADDR0;
  logic [7:0] O_IMC_PIXEL_IN_ADDR1;
  logic [7:0] O_IMC_PIXEL_IN_ADDR2;
  logic [7:0] O_IMC_PIXEL_IN_ADDR3;
  logic [7:0] O_IMC_PIXEL_OUT_ADDRB;
  logic [7:0] O_IMC_PIXEL_OUT_ADDRG;
  logic [7:0] O_IMC_PIXEL_OUT_ADDRR;
  logic       O_IMC_PIX_VALID;
  logic       O_IMC_PIX_LAST;
  logic       O_IMC_DONE;
  logic       O_IMC_BUSY;

  modport slave (
    input  I_IMC_START, I_IMC_ROT, I_IMC_RVALID, I_IMC_OMEM_READY,
    output O_IMC_RREADY,
    output O_IMC_PIXEL_IN_ADDR0, O_IMC_PIXEL_IN_ADDR1, O_IMC_PIXEL_IN_ADDR2, O_IMC_PIXEL_IN_ADDR3,
    output O_IMC_PIXEL_OUT_ADDRB, O_IMC_PIXEL_OUT_ADDRG, O_IMC_PIXEL_OUT_ADDRR,
    output O_IMC_PIX_VALID, O_IMC_PIX_LAST, O_IMC_DONE, O_IMC_BUSY
  );

  modport master (
    output I_IMC_START, I_IMC_ROT, I_IMC_RVALID, I_IMC_OMEM_READY,
    input  O_IMC_RREADY,
    input  O_IMC_PIXEL_IN_ADDR0, O_IMC_PIXEL_IN_ADDR1, O_IMC_PIXEL_IN_ADDR2, O_IMC_PIXEL_IN_ADDR3,
    input  O_IMC_PIXEL_OUT_ADDRB, O_IMC_PIXEL_OUT_ADDRG, O_IMC_PIXEL_OUT_ADDRR,
    input  O_IMC_PIX_VALID, O_IMC_PIX_LAST, O_IMC_DONE, O_IMC_BUSY
  );
endinterface

// File: rtl/imem_rot_ctrl.sv
// imem_rot_ctrl: sequencer for the BGR tile buffer.
//   FILL  : accepts NWORDS bus words, steering word n to byte addresses 4n..4n+3.
//   WAIT  : holds until the output memory can take a whole tile.
//   DRAIN : issues one pixel per cycle as B/G/R read addresses in rotated raster order.
// Ports:
//   I_IMC_HCLK   clock
//   I_IMC_HRESET async reset, active-high
//   bus          imem_rot_ctrl_if.slave (start/rot, word handshake, buffer addresses,
//                pixel valid/last, done, busy)
// Pixel status is delayed one cycle behind the read addresses to line up with the
// registered buffer output.
module imem_rot_ctrl #(
  parameter int TILE_W = 8,
  parameter int TILE_H = 8
) (
  input  logic           I_IMC_HCLK,
  input  logic           I_IMC_HRESET,
  imem_rot_ctrl_if.slave bus
);
  localparam int NPIX   = TILE_W * TILE_H;
  localparam int NWORDS = 3 * NPIX / 4;
  localparam int WCW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int OCW    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int STAGES = 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WAIT, S_DRAIN} state_t;

  state_t           state, nxt;
  logic [WCW-1:0]   wcnt;
  logic [OCW-1:0]   ocnt;
  logic [7:0]       orow, ocol;
  logic [1:0]       rot_q;
  logic [STAGES:0]  vld_pipe, lst_pipe;

  logic             rready, wr_acc, issue, last_pix;
  logic [7:0]       ow_last, sr, sc, baddr, wbase;

  localparam logic [7:0] W1 = 8'(TILE_W - 1);
  localparam logic [7:0] H1 = 8'(TILE_H - 1);

  // next state and per-cycle strobes
  always_comb begin
    nxt      = state;
    rready   = 1'b0;
    wr_acc   = 1'b0;
    issue    = 1'b0;
    last_pix = 1'b0;
    case (state)
      S_IDLE:  if (bus.I_IMC_START) nxt = S_FILL;
      S_FILL: begin
        rready = 1'b1;
        if (bus.I_IMC_RVALID) begin
          wr_acc = 1'b1;
          if (wcnt == WCW'(NWORDS - 1)) nxt = S_WAIT;
        end
      end
      S_WAIT:  if (bus.I_IMC_OMEM_READY) nxt = S_DRAIN;
      S_DRAIN: begin
        issue = 1'b1;
        if (ocnt == OCW'(NPIX - 1)) begin
          last_pix = 1'b1;
          nxt      = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  // rotated output width: W for 0/180, H for 90/270
  assign ow_last = rot_q[0] ? H1 : W1;

  always_ff @(posedge I_IMC_HCLK or posedge I_IMC_HRESET) begin
    if (I_IMC_HRESET) begin
      state <= S_IDLE;
      wcnt  <= '0;
      ocnt  <= '0;
      orow  <= '0;
      ocol  <= '0;
      rot_q <= '0;
    end else begin
      state <= nxt;
      case (state)
        S_IDLE: if (bus.I_IMC_START) begin
          rot_q <= bus.I_IMC_ROT;
          wcnt  <= '0;
        end
        S_FILL: if (wr_acc && wcnt != WCW'(NWORDS - 1)) wcnt <= wcnt + 1'b1;
        S_WAIT: if (bus.I_IMC_OMEM_READY) begin
          ocnt <= '0;
          orow <= '0;
          ocol <= '0;
        end
        S_DRAIN: if (!last_pix) begin
          ocnt <= ocnt + 1'b1;
          // row/col tracked alongside o so no divide is needed
          if (ocol == ow_last) begin
            ocol <= '0;
            orow <= orow + 8'd1;
          end else begin
            ocol <= ocol + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // out (r,c) -> source (sr,sc)
  always_comb begin
    sr = orow;
    sc = ocol;
    case (rot_q)
      2'd1: begin sr = H1 - ocol; sc = orow;        end
      2'd2: begin sr = H1 - orow; sc = W1 - ocol;   end
      2'd3: begin sr = ocol;      sc = W1 - orow;   end
      default: ;
    endcase
  end

  assign baddr = 8'(3 * (int'(sr) * TILE_W + int'(sc)));
  assign wbase = 8'(int'(wcnt) * 4);

  // status pipeline lines up with the registered buffer read
  assign vld_pipe[0] = issue;
  assign lst_pipe[0] = last_pix;

  always_ff @(posedge I_IMC_HCLK or posedge I_IMC_HRESET) begin
    if (I_IMC_HRESET) begin
      vld_pipe[STAGES:1] <= '0;
      lst_pipe[STAGES:1] <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      lst_pipe[STAGES:1] <= lst_pipe[STAGES-1:0];
    end
  end

  assign bus.O_IMC_RREADY = rready;

  // parked addresses sit above the 192-byte buffer so nothing is written or forwarded
  assign bus.O_IMC_PIXEL_IN_ADDR0 = wr_acc ? wbase         : 8'hFC;
  assign bus.O_IMC_PIXEL_IN_ADDR1 = wr_acc ? wbase + 8'd1  : 8'hFD;
  assign bus.O_IMC_PIXEL_IN_ADDR2 = wr_acc ? wbase + 8'd2  : 8'hFE;
  assign bus.O_IMC_PIXEL_IN_ADDR3 = wr_acc ? wbase + 8'd3  : 8'hFF;

  assign bus.O_IMC_PIXEL_OUT_ADDRB = issue ? baddr        : 8'd0;
  assign bus.O_IMC_PIXEL_OUT_ADDRG = issue ? baddr + 8'd1 : 8'd0;
  assign bus.O_IMC_PIXEL_OUT_ADDRR = issue ? baddr + 8'd2 : 8'd0;

  assign bus.O_IMC_PIX_VALID = vld_pipe[STAGES];
  assign bus.O_IMC_PIX_LAST  = lst_pipe[STAGES];
  assign bus.O_IMC_DONE      = lst_pipe[STAGES];
  assign bus.O_IMC_BUSY      = (state != S_IDLE) || vld_pipe[STAGES];
endmodule

// File: tb/tb_imem_rot_ctrl.sv
module tb_imem_rot_ctrl;
  localparam int W = 8;
  localparam int H = 8;
  localparam int NPIX = W * H;
  localparam int NWORDS = 3 * NPIX / 4;

  typedef struct { int b; int last; } px_t;

  logic clk, rst;
  imem_rot_ctrl_if bus();

  imem_rot_ctrl #(.TILE_W(W), .TILE_H(H)) dut (
    .I_IMC_HCLK(clk), .I_IMC_HRESET(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int  n_cmp = 0, n_bad = 0;
  int  wq[$];
  px_t pq[$];
  int  rr_cnt = 0, tile_pix = 0;
  int  prev_b = 0, prev_g = 0, prev_r = 0;
  int  first_b = -1, second_b = -1, last_b = -1;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // monitor: fill-side word scoreboard and pixel scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.I_IMC_RVALID && bus.O_IMC_RREADY) begin
        if (wq.size() == 0) chk("word_unexpected", 1, 0);
        else begin
          int n;
          n = wq.pop_front();
          chk("in_addr0", bus.O_IMC_PIXEL_IN_ADDR0, 4*n);
          chk("in_addr1", bus.O_IMC_PIXEL_IN_ADDR1, 4*n+1);
          chk("in_addr2", bus.O_IMC_PIXEL_IN_ADDR2, 4*n+2);
          chk("in_addr3", bus.O_IMC_PIXEL_IN_ADDR3, 4*n+3);
        end
      end else begin
        chk("in_park", {bus.O_IMC_PIXEL_IN_ADDR0, bus.O_IMC_PIXEL_IN_ADDR1,
                        bus.O_IMC_PIXEL_IN_ADDR2, bus.O_IMC_PIXEL_IN_ADDR3}, 32'hFCFDFEFF);
      end
      if (bus.O_IMC_RREADY) rr_cnt++;
      if (bus.O_IMC_PIX_VALID) begin
        if (pq.size() == 0) chk("pix_unexpected", 1, 0);
        else begin
          px_t e;
          e = pq.pop_front();
          chk("addr_b", prev_b, e.b);
          chk("addr_g", prev_g, e.b + 1);
          chk("addr_r", prev_r, e.b + 2);
          chk("pix_last", bus.O_IMC_PIX_LAST, e.last);
          chk("done", bus.O_IMC_DONE, e.last);
          chk("busy_pv", bus.O_IMC_BUSY, 1);
        end
        if (tile_pix == 0) first_b = prev_b;
        if (tile_pix == 1) second_b = prev_b;
        if (tile_pix == NPIX-1) last_b = prev_b;
        tile_pix++;
      end
    end
    prev_b = bus.O_IMC_PIXEL_OUT_ADDRB;
    prev_g = bus.O_IMC_PIXEL_OUT_ADDRG;
    prev_r = bus.O_IMC_PIXEL_OUT_ADDRR;
  end

  task automatic push_pix(int rot);
    int ow, r, c, sr, sc;
    ow = rot[0] ? H : W;
    for (int o = 0; o < NPIX; o++) begin
      r = o / ow; c = o % ow;
      case (rot)
        1: begin sr = H-1-c; sc = r;     end
        2: begin sr = H-1-r; sc = W-1-c; end
        3: begin sr = c;     sc = W-1-r; end
        default: begin sr = r; sc = c;   end
      endcase
      pq.push_back('{b: 3*(sr*W+sc), last: (o == NPIX-1) ? 1 : 0});
    end
  endtask

  task automatic start_fill(int rot, bit toggle, bit mid_start);
    int n, i;
    tile_pix = 0; first_b = -1; second_b = -1; last_b = -1;
    bus.I_IMC_ROT = 2'(rot);
    bus.I_IMC_START = 1'b1;
    rr_cnt = 0;
    push_pix(rot);
    @(posedge clk); #1;
    bus.I_IMC_START = 1'b0;
    bus.I_IMC_ROT = 2'(rot ^ 1);
    n = 0; i = 0;
    while (n < NWORDS && i < 500) begin
      bus.I_IMC_START = (mid_start && n == 20) ? 1'b1 : 1'b0;
      if (mid_start && n == 20) bus.I_IMC_ROT = 2'(rot ^ 2);
      if (!toggle || i[0]) begin
        bus.I_IMC_RVALID = 1'b1;
        wq.push_back(n);
        n++;
      end else bus.I_IMC_RVALID = 1'b0;
      @(posedge clk); #1;
      i++;
    end
    bus.I_IMC_RVALID = 1'b0;
    bus.I_IMC_START = 1'b0;
    chk("fill_cycles", rr_cnt, toggle ? 96 : 48);
    chk("word_q_empty", wq.size(), 0);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (pq.size() > 0 && k < 400) begin @(posedge clk); k++; end
    if (pq.size() > 0) chk("drain_timeout", pq.size(), 0);
    @(posedge clk); #1;
    chk("busy_after", bus.O_IMC_BUSY, 0);
  endtask

  task automatic tile(int rot, bit toggle, int hold, bit mid_start, int f, int s, int l);
    int k;
    bus.I_IMC_OMEM_READY = (hold == 0);
    start_fill(rot, toggle, mid_start);
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      chk("no_pix_wait", tile_pix, 0);
      chk("busy_wait", bus.O_IMC_BUSY, 1);
      bus.I_IMC_OMEM_READY = 1'b1;
      k = 0;
      while (k < 10) begin
        @(posedge clk); #1; k++;
        if (bus.O_IMC_PIX_VALID) break;
      end
      chk("ready_latency", k, 2);
    end
    wait_drain();
    bus.I_IMC_OMEM_READY = 1'b0;
    chk("pix_count", tile_pix, NPIX);
    chk("first_b", first_b, f);
    chk("second_b", second_b, s);
    chk("last_b", last_b, l);
  endtask

  task automatic chk_reset_outs();
    chk("rst_rready", bus.O_IMC_RREADY, 0);
    chk("rst_pv", bus.O_IMC_PIX_VALID, 0);
    chk("rst_last", bus.O_IMC_PIX_LAST, 0);
    chk("rst_done", bus.O_IMC_DONE, 0);
    chk("rst_busy", bus.O_IMC_BUSY, 0);
    chk("rst_in_park", {bus.O_IMC_PIXEL_IN_ADDR0, bus.O_IMC_PIXEL_IN_ADDR1,
                        bus.O_IMC_PIXEL_IN_ADDR2, bus.O_IMC_PIXEL_IN_ADDR3}, 32'hFCFDFEFF);
    chk("rst_out_addr", {bus.O_IMC_PIXEL_OUT_ADDRB, bus.O_IMC_PIXEL_OUT_ADDRG,
                         bus.O_IMC_PIXEL_OUT_ADDRR}, 0);
  endtask

  initial begin
    int k;
    clk = 0; rst = 1;
    bus.I_IMC_START = 0; bus.I_IMC_ROT = 0; bus.I_IMC_RVALID = 0; bus.I_IMC_OMEM_READY = 0;
    #1;
    chk_reset_outs();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;

    // rotations: hand-computed first / second / last blue addresses
    tile(0, 0, 0, 0, 0,   3,   189);
    tile(1, 0, 0, 0, 168, 144, 21);
    tile(2, 0, 0, 0, 189, 186, 0);
    tile(3, 0, 0, 1, 21,  45,  168);
    // toggling RVALID, sink held off for 20 cycles
    tile(0, 1, 20, 0, 0, 3, 189);

    // async reset in the middle of a drain
    bus.I_IMC_OMEM_READY = 1'b1;
    start_fill(0, 0, 0);
    k = 0;
    while (tile_pix < 10 && k < 200) begin @(posedge clk); k++; end
    chk("reach_pix10", tile_pix, 10);
    #2 rst = 1;
    #1;
    chk_reset_outs();
    pq.delete();
    bus.I_IMC_OMEM_READY = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    k = tile_pix;
    repeat (20) @(posedge clk);
    #1;
    chk("no_pix_after_rst", tile_pix, k);
    chk("busy_after_rst", bus.O_IMC_BUSY, 0);

    // recovers cleanly after the abandoned tile
    tile(2, 0, 0, 0, 189, 186, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 want 0");
    $fatal(1, "timeout");
  end
endmodule
